// File: rtl/stream_mux_arb_pkg.sv
// Shared constants and index helpers for the streaming N:1 multiplexer.
package mux_pkg;

   localparam int MODE_FIXED  = 0;
   localparam int MODE_RR     = 1;
   localparam int MODE_SELECT = 2;

   // Width of a channel index; a 1-channel mux still needs a 1-bit index.
   function automatic int sel_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Next channel index in circular order (NUM_IN-1 wraps to 0).
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Rotating-priority arbiter: the first requester after ptr (circularly) wins.
// With ptr tied to N-1 the search starts at 0, giving fixed lowest-index priority.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int N     = 4,
   localparam int SEL_W = sel_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [SEL_W-1:0] gnt_idx
);

   int  cand;
   logic found;

   // Walk the N channels starting just after ptr; the first active request wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = int'(ptr);
      for (int k = 0; k < N; k++) begin
         cand = wrap_inc(cand, N);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = SEL_W'(cand);
         end
      end
   end

endmodule

// File: rtl/stream_mux_arb.sv
// N:1 streaming multiplexer with per-channel valid/ready and a registered output.
// Channel choice is fixed priority, round-robin, or an external select.
module stream_mux_arb
   import mux_pkg::*;
#(
   parameter  int NUM_IN = 4,
   parameter  int DATA_W = 32,
   parameter  int MODE   = MODE_RR,
   localparam int SEL_W  = sel_width(NUM_IN)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_IN*DATA_W-1:0] in_data,
   input  logic [NUM_IN-1:0]        in_valid,
   output logic [NUM_IN-1:0]        in_ready,
   input  logic [SEL_W-1:0]         sel,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_sel,
   output logic                     out_valid,
   input  logic                     out_ready
);

   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0]  out_sel_q,  out_sel_d;
   logic              out_valid_q, out_valid_d;
   logic [SEL_W-1:0]  rr_ptr_q,   rr_ptr_d;

   logic [SEL_W-1:0]  arb_ptr;
   logic [NUM_IN-1:0] arb_gnt;
   logic [SEL_W-1:0]  arb_idx;

   logic [NUM_IN-1:0] grant;
   logic [SEL_W-1:0]  grant_idx;
   logic              grant_any;
   logic              load;
   logic              xfer;
   logic [DATA_W-1:0] mux_data;

   // Fixed priority is the rotating arbiter frozen with its pointer at the last channel.
   assign arb_ptr = (MODE == MODE_RR) ? rr_ptr_q : SEL_W'(NUM_IN - 1);

   rr_arbiter #(.N(NUM_IN)) u_arb (
      .req     (in_valid),
      .ptr     (arb_ptr),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   // Grant source: external select (out-of-range select grants nobody) or the arbiter.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      if (MODE == MODE_SELECT) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
               grant[i]  = 1'b1;
               grant_idx = SEL_W'(i);
            end
         end
      end else begin
         grant     = arb_gnt;
         grant_idx = arb_idx;
      end
   end

   assign grant_any = |grant;
   assign load      = !out_valid_q || out_ready;
   assign in_ready  = rst ? '0 : (grant & {NUM_IN{load}});
   assign xfer      = !rst && load && grant_any;

   // One-hot data select of the granted channel.
   always_comb begin
      mux_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant[i]) mux_data = in_data[i*DATA_W +: DATA_W];
      end
   end

   // Next output-register contents: load a new beat, drain to empty, or hold under backpressure.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      rr_ptr_d    = rr_ptr_q;
      if (load) out_valid_d = grant_any;
      if (xfer) begin
         out_data_d = mux_data;
         out_sel_d  = grant_idx;
         if (MODE == MODE_RR) rr_ptr_d = grant_idx;
      end
   end

   // Output register and round-robin pointer; pointer resets so channel 0 is searched first.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         rr_ptr_q    <= SEL_W'(NUM_IN - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: one instance per arbitration mode sharing the same
// stimulus, each compared every cycle against a behavioural model of its mode.
module tb_stream_mux_arb;
   import mux_pkg::*;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int SW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [SW-1:0]  sel;
   logic           out_ready;

   logic [N-1:0]   in_ready  [3];
   logic [W-1:0]   out_data  [3];
   logic [SW-1:0]  out_sel   [3];
   logic           out_valid [3];

   int n_tests = 0;
   int n_fail  = 0;

   // model state per mode (index = MODE value)
   logic         m_v   [3];
   logic [W-1:0] m_d   [3];
   int           m_s   [3];
   int           m_ptr [3];

   always #5 clk = ~clk;

   for (genvar m = 0; m < 3; m++) begin : g_dut
      stream_mux_arb #(.NUM_IN(N), .DATA_W(W), .MODE(m)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_data   (in_data),
         .in_valid  (in_valid),
         .in_ready  (in_ready[m]),
         .sel       (sel),
         .out_data  (out_data[m]),
         .out_sel   (out_sel[m]),
         .out_valid (out_valid[m]),
         .out_ready (out_ready)
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Channel chosen by the rules of each mode, -1 for none.
   function automatic int pick(input int mode, input int ptr);
      if (mode == MODE_SELECT)
         return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
      if (mode == MODE_FIXED) begin
         for (int i = 0; i < N; i++) if (in_valid[i]) return i;
         return -1;
      end
      for (int k = 1; k <= N; k++) if (in_valid[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 3; m++) begin
         m_v[m] = 1'b0; m_d[m] = '0; m_s[m] = 0; m_ptr[m] = N - 1;
      end
   endtask

   // One clock: check ready before the edge, advance model, check outputs after it.
   task automatic step();
      int         w   [3];
      logic       ld  [3];
      logic [N-1:0] exp_rdy;
      #1;
      for (int m = 0; m < 3; m++) begin
         w[m]  = pick(m, m_ptr[m]);
         ld[m] = !m_v[m] || out_ready;
         exp_rdy = '0;
         if (!rst && ld[m] && w[m] >= 0) exp_rdy[w[m]] = 1'b1;
         chk($sformatf("in_ready_mode%0d", m), 32'(in_ready[m]), 32'(exp_rdy));
      end
      @(posedge clk);
      if (rst) model_reset();
      else begin
         for (int m = 0; m < 3; m++) begin
            if (ld[m]) begin
               if (w[m] >= 0) begin
                  m_v[m] = 1'b1;
                  m_d[m] = in_data[w[m]*W +: W];
                  m_s[m] = w[m];
                  if (m == MODE_RR) m_ptr[m] = w[m];
               end else m_v[m] = 1'b0;
            end
         end
      end
      #1;
      for (int m = 0; m < 3; m++) begin
         chk($sformatf("out_valid_mode%0d", m), 32'(out_valid[m]), 32'(m_v[m]));
         chk($sformatf("out_data_mode%0d", m), out_data[m], m_d[m]);
         chk($sformatf("out_sel_mode%0d", m), 32'(out_sel[m]), 32'(m_s[m]));
      end
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      rst = 1'b1; out_ready = 1'b1; sel = '0; in_valid = '1;
      for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hAAAA0000 + 32'(i) * 32'h11110000;
      @(negedge clk);

      // reset with every channel valid
      step(); step();
      chk("reset_out_valid", 32'(out_valid[MODE_RR]), 32'd0);
      chk("reset_out_data", out_data[MODE_RR], 32'd0);
      rst = 1'b0;

      // select sweep
      for (int s = 0; s < N; s++) begin
         sel = SW'(s);
         step();
         chk("sel_sweep_data", out_data[MODE_SELECT], 32'hAAAA0000 + 32'(s) * 32'h11110000);
         chk("sel_sweep_sel", 32'(out_sel[MODE_SELECT]), 32'(s));
      end

      // fixed priority
      in_valid = 4'b1110;
      repeat (3) begin step(); chk("fixed_sel1", 32'(out_sel[MODE_FIXED]), 32'd1); end
      in_valid = 4'b1100;
      repeat (2) begin step(); chk("fixed_sel2", 32'(out_sel[MODE_FIXED]), 32'd2); end
      in_valid = 4'b0000;
      repeat (2) begin step(); chk("fixed_empty", 32'(out_valid[MODE_FIXED]), 32'd0); end

      // round robin from a clean start
      rst = 1'b1; step(); rst = 1'b0;
      in_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("rr_full", 32'(out_sel[MODE_RR]), 32'(k % N));
      end
      in_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("rr_sparse", 32'(out_sel[MODE_RR]), (k % 2 == 0) ? 32'd3 : 32'd1);
      end

      // backpressure mid-stream
      in_valid = 4'b1111;
      repeat (2) step();
      out_ready = 1'b0;
      repeat (3) step();
      out_ready = 1'b1;
      repeat (5) step();

      // reset while a beat is held
      rst = 1'b1; step();
      chk("midrst_valid", 32'(out_valid[MODE_RR]), 32'd0);
      rst = 1'b0; step();
      chk("midrst_restart", 32'(out_sel[MODE_RR]), 32'd0);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
         in_valid  = N'($urandom);
         sel       = SW'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         rst       = ($urandom_range(0, 49) == 0);
         step();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
